// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the multi-cycle control unit: opcodes, ALU
// operation codes, FSM states and datapath mux select values.
package rv32i_pkg;

  localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
  localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
  localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
  localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

  // ALU operations encoded as {funct7[5], funct3}
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_e;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [2:0] RFWD_ALU   = 3'd0;
  localparam logic [2:0] RFWD_MEM   = 3'd1;
  localparam logic [2:0] RFWD_IMM   = 3'd2;
  localparam logic [2:0] RFWD_AUIPC = 3'd3;
  localparam logic [2:0] RFWD_PC4   = 3'd4;

  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_PC_IMM = 2'd1;
  localparam logic [1:0] PCSRC_RS1    = 2'd2;

  // One-hot instruction class; all-zero means unknown opcode
  typedef struct packed {
    logic r;
    logic i;
    logic l;
    logic s;
    logic b;
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
  } instr_class_t;

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational opcode classifier and ALU operation generator.
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  output instr_class_t cls,
  output logic         known,
  output logic [3:0]   alu_ctrl
);

  // Classify the opcode and pick the ALU operation for that class
  always_comb begin
    cls      = '0;
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_TYPE_R: begin
        cls.r    = 1'b1;
        alu_ctrl = {funct7_5, funct3};
      end
      OP_TYPE_I: begin
        cls.i = 1'b1;
        // Bit 30 is an immediate bit for everything but the shifts
        if (funct3 == 3'b001 || funct3 == 3'b101) alu_ctrl = {funct7_5, funct3};
        else                                       alu_ctrl = {1'b0, funct3};
      end
      OP_TYPE_L:  cls.l = 1'b1;
      OP_TYPE_S:  cls.s = 1'b1;
      OP_TYPE_B: begin
        cls.b    = 1'b1;
        alu_ctrl = {1'b0, funct3};
      end
      OP_TYPE_LU: cls.lui   = 1'b1;
      OP_TYPE_AU: cls.auipc = 1'b1;
      OP_TYPE_J:  cls.jal   = 1'b1;
      OP_TYPE_JL: cls.jalr  = 1'b1;
      default: ;
    endcase
  end

  assign known = |cls;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXE/MEM/WB sequencing with
// combinational datapath enables per state.
module multicycle_control_unit
  import rv32i_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instrCode,
  input  logic                  btaken,
  input  logic                  mem_ready,
  output logic                  irWe,
  output logic                  pcEn,
  output logic [1:0]            pcSrcSel,
  output logic                  regFileWe,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  aluSrcMuxSel,
  output logic                  dataWe,
  output logic                  dataRe,
  output logic [2:0]            memSize,
  output logic [2:0]            RFWDSrcMuxSel,
  output logic                  illegal_instr,
  output logic [2:0]            state_o
);

  state_e       state_q, state_d;
  instr_class_t cls;
  logic         known;
  logic [3:0]   alu_ctrl;
  logic [2:0]   funct3;
  logic         mem_done;

  // Immediate, register and upper bits are consumed by the datapath, not here
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  assign funct3   = instrCode[14:12];
  assign mem_done = !MEM_WAIT_EN || mem_ready;

  rv32i_decoder u_decoder (
    .opcode   (instrCode[6:0]),
    .funct3   (funct3),
    .funct7_5 (instrCode[30]),
    .cls      (cls),
    .known    (known),
    .alu_ctrl (alu_ctrl)
  );

  // State register; reset always returns to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state datapath controls; reset masks every strobe
  always_comb begin
    state_d       = state_q;
    irWe          = 1'b0;
    pcEn          = 1'b0;
    pcSrcSel      = PCSRC_PC4;
    regFileWe     = 1'b0;
    aluControl    = '0;
    aluSrcMuxSel  = 1'b0;
    dataWe        = 1'b0;
    dataRe        = 1'b0;
    memSize       = 3'd0;
    RFWDSrcMuxSel = RFWD_ALU;
    illegal_instr = 1'b0;
    state_o       = state_q;

    case (state_q)
      FETCH: begin
        irWe    = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (known) begin
          state_d = EXE;
        end else begin
          // Skip the unknown instruction and move on to pc+4
          illegal_instr = 1'b1;
          pcEn          = 1'b1;
          pcSrcSel      = PCSRC_PC4;
          state_d       = FETCH;
        end
      end
      EXE: begin
        aluControl   = ALU_CTRL_W'(alu_ctrl);
        aluSrcMuxSel = cls.i | cls.l | cls.s | cls.jalr;
        state_d      = FETCH;
        if (cls.l || cls.s) begin
          state_d = MEM;
        end else if (cls.b) begin
          pcEn     = 1'b1;
          pcSrcSel = btaken ? PCSRC_PC_IMM : PCSRC_PC4;
        end else if (cls.r || cls.i) begin
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = RFWD_ALU;
          pcEn          = 1'b1;
        end else if (cls.lui) begin
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = RFWD_IMM;
          pcEn          = 1'b1;
        end else if (cls.auipc) begin
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = RFWD_AUIPC;
          pcEn          = 1'b1;
        end else if (cls.jal || cls.jalr) begin
          regFileWe     = 1'b1;
          RFWDSrcMuxSel = RFWD_PC4;
          pcEn          = 1'b1;
          pcSrcSel      = cls.jalr ? PCSRC_RS1 : PCSRC_PC_IMM;
        end
      end
      MEM: begin
        memSize    = funct3;
        aluControl = ALU_CTRL_W'(ALU_ADD);
        dataRe     = cls.l;
        dataWe     = cls.s;
        // Strobes stay asserted until the memory reports completion
        if (mem_done) begin
          if (cls.l) begin
            state_d = WB;
          end else begin
            pcEn    = 1'b1;
            state_d = FETCH;
          end
        end
      end
      WB: begin
        RFWDSrcMuxSel = RFWD_MEM;
        regFileWe     = 1'b1;
        pcEn          = 1'b1;
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (reset) begin
      state_d       = FETCH;
      irWe          = 1'b0;
      pcEn          = 1'b0;
      pcSrcSel      = PCSRC_PC4;
      regFileWe     = 1'b0;
      aluControl    = '0;
      aluSrcMuxSel  = 1'b0;
      dataWe        = 1'b0;
      dataRe        = 1'b0;
      memSize       = 3'd0;
      RFWDSrcMuxSel = RFWD_ALU;
      illegal_instr = 1'b0;
      state_o       = FETCH;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multi-cycle RV32I control unit.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instrCode = 32'h0;
  logic        btaken = 1'b0;
  logic        mem_ready = 1'b0;

  logic        irWe, pcEn, regFileWe, aluSrcMuxSel, dataWe, dataRe, illegal_instr;
  logic [1:0]  pcSrcSel;
  logic [3:0]  aluControl;
  logic [2:0]  memSize, RFWDSrcMuxSel, state_o;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;

  multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_WAIT_EN(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .instrCode     (instrCode),
    .btaken        (btaken),
    .mem_ready     (mem_ready),
    .irWe          (irWe),
    .pcEn          (pcEn),
    .pcSrcSel      (pcSrcSel),
    .regFileWe     (regFileWe),
    .aluControl    (aluControl),
    .aluSrcMuxSel  (aluSrcMuxSel),
    .dataWe        (dataWe),
    .dataRe        (dataRe),
    .memSize       (memSize),
    .RFWDSrcMuxSel (RFWDSrcMuxSel),
    .illegal_instr (illegal_instr),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  wire [21:0] obs = {irWe, pcEn, pcSrcSel, regFileWe, aluControl, aluSrcMuxSel,
                     dataWe, dataRe, memSize, RFWDSrcMuxSel, illegal_instr, state_o};

  function automatic logic [21:0] v(input logic irwe, input logic pcen, input logic [1:0] pcs,
                                    input logic rfwe, input logic [3:0] alu, input logic src,
                                    input logic dwe, input logic dre, input logic [2:0] msz,
                                    input logic [2:0] rfwd, input logic ill, input logic [2:0] st);
    return {irwe, pcen, pcs, rfwe, alu, src, dwe, dre, msz, rfwd, ill, st};
  endfunction

  localparam logic [21:0] F_V = {1'b1, 21'd0};
  localparam logic [21:0] D_V = 22'd1;

  // One clock: drive inputs just after the falling edge, sample 1ns later
  task automatic cyc(input logic [31:0] ins, input logic bt, input logic rdy);
    @(negedge clk);
    reset     = 1'b0;
    instrCode = ins;
    btaken    = bt;
    mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== 22'd0) begin
      errors++;
      $display("FAIL reset obs=%h exp=%h", obs, 22'd0);
    end
  endtask

  task automatic test_r_type();
    logic [31:0] ins[3] = '{32'h002081B3, 32'h402081B3, 32'h0020C1B3};
    logic [21:0] ex[3];
    ex[0] = v(0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, S_E);
    ex[1] = v(0, 1, 0, 1, 4'b1000, 0, 0, 0, 0, 0, 0, S_E);
    ex[2] = v(0, 1, 0, 1, 4'b0100, 0, 0, 0, 0, 0, 0, S_E);
    for (int n = 0; n < 3; n++) begin
      logic [21:0] seq[3];
      seq = '{F_V, D_V, ex[n]};
      for (int c = 0; c < 3; c++) begin
        cyc(ins[n], 1'b0, 1'b0);
        checks++;
        if (obs !== seq[c]) begin
          errors++;
          $display("FAIL r_type[%0d] c%0d obs=%h exp=%h", n, c, obs, seq[c]);
        end
      end
    end
  endtask

  task automatic test_i_type();
    // ADDI imm=0x400, SRAI 3, SRLI 3, XORI imm=0x400
    logic [31:0] ins[4] = '{32'h40008093, 32'h4030D093, 32'h0030D093, 32'h4000C093};
    logic [21:0] ex[4];
    ex[0] = v(0, 1, 0, 1, 4'b0000, 1, 0, 0, 0, 0, 0, S_E);
    ex[1] = v(0, 1, 0, 1, 4'b1101, 1, 0, 0, 0, 0, 0, S_E);
    ex[2] = v(0, 1, 0, 1, 4'b0101, 1, 0, 0, 0, 0, 0, S_E);
    ex[3] = v(0, 1, 0, 1, 4'b0100, 1, 0, 0, 0, 0, 0, S_E);
    for (int n = 0; n < 4; n++) begin
      logic [21:0] seq[3];
      seq = '{F_V, D_V, ex[n]};
      for (int c = 0; c < 3; c++) begin
        cyc(ins[n], 1'b0, 1'b0);
        checks++;
        if (obs !== seq[c]) begin
          errors++;
          $display("FAIL i_type[%0d] c%0d obs=%h exp=%h", n, c, obs, seq[c]);
        end
      end
    end
  endtask

  task automatic test_upper_jump();
    // LUI, AUIPC, JAL, JALR imm=0x400
    logic [31:0] ins[4] = '{32'h123450B7, 32'h00001097, 32'h008000EF, 32'h400080E7};
    logic [21:0] ex[4];
    ex[0] = v(0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 3'd2, 0, S_E);
    ex[1] = v(0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 3'd3, 0, S_E);
    ex[2] = v(0, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 3'd4, 0, S_E);
    ex[3] = v(0, 1, 2, 1, 4'b0000, 1, 0, 0, 0, 3'd4, 0, S_E);
    for (int n = 0; n < 4; n++) begin
      logic [21:0] seq[3];
      seq = '{F_V, D_V, ex[n]};
      for (int c = 0; c < 3; c++) begin
        cyc(ins[n], 1'b0, 1'b0);
        checks++;
        if (obs !== seq[c]) begin
          errors++;
          $display("FAIL upper_jump[%0d] c%0d obs=%h exp=%h", n, c, obs, seq[c]);
        end
      end
    end
  endtask

  task automatic test_branch();
    // BEQ taken, BEQ not taken, BNE taken
    logic [31:0] ins[3] = '{32'h00208463, 32'h00208463, 32'h00209463};
    logic        bt[3]  = '{1'b1, 1'b0, 1'b1};
    logic [21:0] ex[3];
    ex[0] = v(0, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, S_E);
    ex[1] = v(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, S_E);
    ex[2] = v(0, 1, 1, 0, 4'b0001, 0, 0, 0, 0, 0, 0, S_E);
    for (int n = 0; n < 3; n++) begin
      logic [21:0] seq[3];
      seq = '{F_V, D_V, ex[n]};
      for (int c = 0; c < 3; c++) begin
        cyc(ins[n], bt[n], 1'b0);
        checks++;
        if (obs !== seq[c]) begin
          errors++;
          $display("FAIL branch[%0d] c%0d obs=%h exp=%h", n, c, obs, seq[c]);
        end
      end
    end
  endtask

  task automatic test_load_wait();
    // LW with three not-ready cycles: 8 cycles total
    logic        rdy[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic [21:0] seq[8];
    seq[0] = F_V;
    seq[1] = D_V;
    seq[2] = v(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, S_E);
    for (int k = 3; k < 7; k++) seq[k] = v(0, 0, 0, 0, 4'b0000, 0, 0, 1, 3'b010, 0, 0, S_M);
    seq[7] = v(0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 3'd1, 0, S_W);
    for (int c = 0; c < 8; c++) begin
      cyc(32'h0000A103, 1'b0, rdy[c]);
      checks++;
      if (obs !== seq[c]) begin
        errors++;
        $display("FAIL load_wait c%0d obs=%h exp=%h", c, obs, seq[c]);
      end
    end
  endtask

  task automatic test_back_to_back_mem();
    // LBU (no wait, 5 cycles) then SW with one wait cycle (5 cycles)
    logic [31:0] ins[10];
    logic        rdy[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    logic [21:0] seq[10];
    for (int k = 0; k < 5; k++)  ins[k] = 32'h0000C103;
    for (int k = 5; k < 10; k++) ins[k] = 32'h0020A223;
    seq[0] = F_V;
    seq[1] = D_V;
    seq[2] = v(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, S_E);
    seq[3] = v(0, 0, 0, 0, 4'b0000, 0, 0, 1, 3'b100, 0, 0, S_M);
    seq[4] = v(0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 3'd1, 0, S_W);
    seq[5] = F_V;
    seq[6] = D_V;
    seq[7] = v(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, S_E);
    seq[8] = v(0, 0, 0, 0, 4'b0000, 0, 1, 0, 3'b010, 0, 0, S_M);
    seq[9] = v(0, 1, 0, 0, 4'b0000, 0, 1, 0, 3'b010, 0, 0, S_M);
    for (int c = 0; c < 10; c++) begin
      cyc(ins[c], 1'b0, rdy[c]);
      checks++;
      if (obs !== seq[c]) begin
        errors++;
        $display("FAIL back_to_back_mem c%0d obs=%h exp=%h", c, obs, seq[c]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [21:0] seq[2];
    seq[0] = F_V;
    seq[1] = v(0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, S_D);
    for (int c = 0; c < 2; c++) begin
      cyc(32'h0000007F, 1'b0, 1'b0);
      checks++;
      if (obs !== seq[c]) begin
        errors++;
        $display("FAIL illegal c%0d obs=%h exp=%h", c, obs, seq[c]);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [21:0] seq[5];
    seq[0] = F_V;
    seq[1] = D_V;
    seq[2] = v(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, S_E);
    seq[3] = v(0, 0, 0, 0, 4'b0000, 0, 1, 0, 3'b001, 0, 0, S_M);
    seq[4] = seq[3];
    // SH stalled in MEM
    for (int c = 0; c < 5; c++) begin
      cyc(32'h00209223, 1'b0, 1'b0);
      checks++;
      if (obs !== seq[c]) begin
        errors++;
        $display("FAIL reset_mid c%0d obs=%h exp=%h", c, obs, seq[c]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid in_reset obs=%h exp=%h", obs, 22'd0);
    end
    // After reset, the next instruction (ADD) runs from FETCH
    seq[0] = F_V;
    seq[1] = D_V;
    seq[2] = v(0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, S_E);
    for (int c = 0; c < 3; c++) begin
      cyc(32'h002081B3, 1'b0, 1'b0);
      checks++;
      if (obs !== seq[c]) begin
        errors++;
        $display("FAIL reset_mid resume c%0d obs=%h exp=%h", c, obs, seq[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_upper_jump();
    test_branch();
    test_load_wait();
    test_back_to_back_mem();
    test_illegal();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
